// File: rtl/aibcr3aux_por_seq.sv
// ============================================================================
//  Module   : aibcr3aux_por_seq
//  Purpose  : Power-on-reset and reset-release sequencer for the AIB aux
//             channel. Each of NUM_DOM supply domains is synchronized and
//             debounced. The sequencer releases o_dn_por first and then,
//             RST_DLY cycles later, o_dn_rst_n. In RUN it accepts a warm-reset
//             request that pulses o_dn_rst_n low for RST_DLY cycles.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: AIBCR3AUX_POR_OVRD_EN
//    When defined, a synchronized iovrd[i]=1 forces domain i good at once.
//    When undefined, iovrd is accepted on the port but ignored.
// ----------------------------------------------------------------------------
//  Ports
//    iclk        in   1        sequencer clock
//    irst        in   1        synchronous active-high reset
//    ipwr_ok     in   NUM_DOM  raw per-domain supply-good (asynchronous)
//    iovrd       in   NUM_DOM  per-domain force-good override (asynchronous)
//    isw_rst_req in   1        warm-reset request (synchronous level)
//    o_por       out  NUM_DOM  per-domain POR, 1 = domain not yet good
//    o_dn_por    out  1        aux POR to far side, 1 = in POR
//    o_dn_rst_n  out  1        aux reset to far side, 0 = in reset
//    o_state     out  2        POR=0, DLY=1, RUN=2, SWRST=3
//    o_seq_done  out  1        1 while in RUN
// ============================================================================
`default_nettype none

module aibcr3aux_por_seq #(
    parameter int NUM_DOM = 3,
    parameter int DEB_W   = 8,
    parameter int DEB_CNT = 200,
    parameter int DLY_W   = 5,
    parameter int RST_DLY = 16
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic [NUM_DOM-1:0] ipwr_ok,
    input  logic [NUM_DOM-1:0] iovrd,
    input  logic               isw_rst_req,
    output logic [NUM_DOM-1:0] o_por,
    output logic               o_dn_por,
    output logic               o_dn_rst_n,
    output logic [1:0]         o_state,
    output logic               o_seq_done
);

    localparam logic [DEB_W-1:0] c_deb_max  = DEB_W'(DEB_CNT);
    localparam logic [DLY_W-1:0] c_dly_last = DLY_W'(RST_DLY - 1);

    localparam logic [1:0] c_st_por   = 2'd0;
    localparam logic [1:0] c_st_dly   = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;
    localparam logic [1:0] c_st_swrst = 2'd3;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous supply-good inputs
    // ------------------------------------------------------------------
    logic [NUM_DOM-1:0] r_ok_s1;
    logic [NUM_DOM-1:0] r_ok_s2;

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_ok_s1 <= '0;
            r_ok_s2 <= '0;
        end else begin
            r_ok_s1 <= ipwr_ok;
            r_ok_s2 <= r_ok_s1;
        end
    end

`ifdef AIBCR3AUX_POR_OVRD_EN
    logic [NUM_DOM-1:0] r_ov_s1;
    logic [NUM_DOM-1:0] r_ov_s2;

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_ov_s1 <= '0;
            r_ov_s2 <= '0;
        end else begin
            r_ov_s1 <= iovrd;
            r_ov_s2 <= r_ov_s1;
        end
    end
`else
    // Override disabled: the port remains for pin compatibility only.
    logic w_unused_ovrd;
    assign w_unused_ovrd = ^iovrd;
`endif

    // ------------------------------------------------------------------
    // Per-domain debounce: count consecutive good samples up to DEB_CNT.
    // A bad sample clears the count, so o_por rises on the same edge.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_dom
        logic [DEB_W-1:0] r_cnt;
        logic             w_load;

`ifdef AIBCR3AUX_POR_OVRD_EN
        assign w_load = r_ov_s2[gi];
`else
        assign w_load = 1'b0;
`endif

        always_ff @(posedge iclk) begin
            if (irst) begin
                r_cnt <= '0;
            end else if (w_load) begin
                r_cnt <= c_deb_max;
            end else if (!r_ok_s2[gi]) begin
                r_cnt <= '0;
            end else if (r_cnt != c_deb_max) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign o_por[gi] = (r_cnt != c_deb_max);
    end

    // ------------------------------------------------------------------
    // Release sequencer. r_dly is cleared whenever it is not counting, so
    // every entry into DLY or SWRST starts the delay from zero.
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [DLY_W-1:0] r_dly;
    logic             w_any_por;

    assign w_any_por = |o_por;

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state <= c_st_por;
            r_dly   <= '0;
        end else begin
            r_dly <= '0;
            case (r_state)
                c_st_por: begin
                    if (!w_any_por) begin
                        r_state <= c_st_dly;
                    end
                end
                c_st_dly, c_st_swrst: begin
                    // Supply loss has priority and abandons the delay count.
                    if (w_any_por) begin
                        r_state <= c_st_por;
                    end else if (r_dly == c_dly_last) begin
                        r_state <= c_st_run;
                    end else begin
                        r_dly <= r_dly + 1'b1;
                    end
                end
                c_st_run: begin
                    if (w_any_por) begin
                        r_state <= c_st_por;
                    end else if (isw_rst_req) begin
                        r_state <= c_st_swrst;
                    end
                end
                default: begin
                    r_state <= c_st_por;
                end
            endcase
        end
    end

    assign o_dn_por   = (r_state == c_st_por);
    assign o_dn_rst_n = (r_state == c_st_run);
    assign o_seq_done = (r_state == c_st_run);
    assign o_state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_aibcr3aux_por_seq.sv
// ============================================================================
//  Module   : tb_aibcr3aux_por_seq
//  Purpose  : Scoreboard testbench for aibcr3aux_por_seq. A reference model
//             derived from the sequencing rules predicts the outputs after
//             every clock edge; a monitor compares them on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aibcr3aux_por_seq;

    localparam int NUM_DOM = 3;
    localparam int DEB_W   = 8;
    localparam int DEB_CNT = 200;
    localparam int DLY_W   = 5;
    localparam int RST_DLY = 16;

    localparam int MODE_POR   = 0;
    localparam int MODE_DLY   = 1;
    localparam int MODE_RUN   = 2;
    localparam int MODE_SWRST = 3;

    logic               iclk = 1'b0;
    logic               irst = 1'b1;
    logic [NUM_DOM-1:0] ipwr_ok = '0;
    logic [NUM_DOM-1:0] iovrd = '0;
    logic               isw_rst_req = 1'b0;
    logic [NUM_DOM-1:0] o_por;
    logic               o_dn_por;
    logic               o_dn_rst_n;
    logic [1:0]         o_state;
    logic               o_seq_done;

    always #5 iclk = ~iclk;

    aibcr3aux_por_seq #(
        .NUM_DOM (NUM_DOM),
        .DEB_W   (DEB_W),
        .DEB_CNT (DEB_CNT),
        .DLY_W   (DLY_W),
        .RST_DLY (RST_DLY)
    ) dut (
        .iclk        (iclk),
        .irst        (irst),
        .ipwr_ok     (ipwr_ok),
        .iovrd       (iovrd),
        .isw_rst_req (isw_rst_req),
        .o_por       (o_por),
        .o_dn_por    (o_dn_por),
        .o_dn_rst_n  (o_dn_rst_n),
        .o_state     (o_state),
        .o_seq_done  (o_seq_done)
    );

    typedef struct {
        int          cyc;
        logic [2:0]  por;
        logic        dn_por;
        logic        rst_n;
        logic [1:0]  st;
        logic        done;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: inputs reach the debounce logic three edges after
    // they are applied; the release sequence is tracked as a countdown.
    int                 good [NUM_DOM];
    logic [NUM_DOM-1:0] ok_d1 = '0, ok_d2 = '0, ov_d1 = '0, ov_d2 = '0;
    int                 mode  = MODE_POR;
    int                 timer = 0;

    function automatic void model_edge(input logic r, input logic [NUM_DOM-1:0] ok,
                                       input logic [NUM_DOM-1:0] ov, input logic req);
        logic any_bad;
        logic ovr;
        any_bad = 1'b0;
        for (int i = 0; i < NUM_DOM; i++) if (good[i] != DEB_CNT) any_bad = 1'b1;
        if (r) begin
            for (int i = 0; i < NUM_DOM; i++) good[i] = 0;
            ok_d1 = '0; ok_d2 = '0; ov_d1 = '0; ov_d2 = '0;
            mode = MODE_POR; timer = 0;
        end else begin
            case (mode)
                MODE_POR: if (!any_bad) begin mode = MODE_DLY; timer = RST_DLY; end
                MODE_DLY, MODE_SWRST: begin
                    if (any_bad) mode = MODE_POR;
                    else begin
                        timer = timer - 1;
                        if (timer == 0) mode = MODE_RUN;
                    end
                end
                default: begin
                    if (any_bad) mode = MODE_POR;
                    else if (req) begin mode = MODE_SWRST; timer = RST_DLY; end
                end
            endcase
            for (int i = 0; i < NUM_DOM; i++) begin
                ovr = 1'b0;
`ifdef AIBCR3AUX_POR_OVRD_EN
                ovr = ov_d2[i];
`endif
                if (ovr) good[i] = DEB_CNT;
                else if (ok_d2[i]) good[i] = (good[i] < DEB_CNT) ? good[i] + 1 : DEB_CNT;
                else good[i] = 0;
            end
            ok_d2 = ok_d1; ok_d1 = ok;
            ov_d2 = ov_d1; ov_d1 = ov;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.cyc = cyc;
        for (int i = 0; i < NUM_DOM; i++) e.por[i] = (good[i] != DEB_CNT);
        e.dn_por = (mode == MODE_POR);
        e.rst_n  = (mode == MODE_RUN);
        e.st     = 2'(mode);
        e.done   = (mode == MODE_RUN);
        return e;
    endfunction

    // Apply one set of inputs, let one edge pass, push the prediction.
    task automatic step(input logic r, input logic [NUM_DOM-1:0] ok,
                        input logic [NUM_DOM-1:0] ov, input logic req);
        irst = r; ipwr_ok = ok; iovrd = ov; isw_rst_req = req;
        @(posedge iclk);
        cyc++;
        model_edge(r, ok, ov, req);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic chk(input string name, input int c, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, want);
        end
    endtask

    always @(negedge iclk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("o_por",      e.cyc, int'(o_por),      int'(e.por));
            chk("o_dn_por",   e.cyc, int'(o_dn_por),   int'(e.dn_por));
            chk("o_dn_rst_n", e.cyc, int'(o_dn_rst_n), int'(e.rst_n));
            chk("o_state",    e.cyc, int'(o_state),    int'(e.st));
            chk("o_seq_done", e.cyc, int'(o_seq_done), int'(e.done));
        end
    end

    initial begin
        logic [NUM_DOM-1:0] ok;
        logic [NUM_DOM-1:0] ov;
        for (int i = 0; i < NUM_DOM; i++) good[i] = 0;

        // Reset, then all domains rise together and sequence to RUN.
        repeat (3) step(1'b1, '0, '0, 1'b0);
        repeat (8) step(1'b0, '0, '0, 1'b0);
        repeat (240) step(1'b0, 3'b111, '0, 1'b0);

        // Single-cycle warm reset, then a held request.
        step(1'b0, 3'b111, '0, 1'b1);
        repeat (25) step(1'b0, 3'b111, '0, 1'b0);
        repeat (60) step(1'b0, 3'b111, '0, 1'b1);
        repeat (5) step(1'b0, 3'b111, '0, 1'b0);

        // Supply loss on domain 0 part-way through a warm reset.
        step(1'b0, 3'b111, '0, 1'b1);
        repeat (5) step(1'b0, 3'b111, '0, 1'b0);
        repeat (8) step(1'b0, 3'b110, '0, 1'b0);
        repeat (230) step(1'b0, 3'b111, '0, 1'b0);

        // Staggered rise: domain 2 late, domain 1 glitches once.
        repeat (5) step(1'b0, '0, '0, 1'b0);
        for (int t = 0; t < 300; t++) begin
            ok[0] = 1'b1;
            ok[1] = (t != 150);
            ok[2] = (t >= 50);
            step(1'b0, ok, '0, 1'b0);
        end

        // Randomized: mostly-good supplies with rare drops, random requests,
        // sparse override pulses.
        for (int t = 0; t < 1500; t++) begin
            ok = 3'b111;
            ov = '0;
            for (int i = 0; i < NUM_DOM; i++) begin
                if ($urandom_range(0, 399) == 0) ok[i] = 1'b0;
                if ($urandom_range(0, 99) == 0) ov[i] = 1'b1;
            end
            step(1'b0, ok, ov, 1'($urandom_range(0, 19) == 0));
        end

        // Make sure RUN is reached, then reset synchronously from RUN.
        repeat (240) step(1'b0, 3'b111, '0, 1'b0);
        step(1'b1, 3'b111, '0, 1'b0);
        repeat (4) step(1'b0, 3'b111, '0, 1'b0);

        // Overrides with all supplies low, then overrides removed.
        step(1'b1, '0, '0, 1'b0);
        repeat (40) step(1'b0, '0, 3'b111, 1'b0);
        repeat (10) step(1'b0, '0, '0, 1'b0);

        @(negedge iclk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
